// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS main control.
// Optional macro MC_CTRL_ADDI_EN adds the addi instruction and its ADDI_EX state.
package mc_ctrl_pkg;

    // Opcodes taken from IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // State encodings; INIT is zero, ADDI_EX takes the last slot
    localparam logic [3:0] S_INIT    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEM_ADR = 4'd3;
    localparam logic [3:0] S_MEM_RD  = 4'd4;
    localparam logic [3:0] S_MEM_WB  = 4'd5;
    localparam logic [3:0] S_MEM_WR  = 4'd6;
    localparam logic [3:0] S_R_EX    = 4'd7;
    localparam logic [3:0] S_R_WB    = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_ORI_EX  = 4'd10;
    localparam logic [3:0] S_IMM_WB  = 4'd11;
    localparam logic [3:0] S_JUMP    = 4'd12;
`ifdef MC_CTRL_ADDI_EN
    localparam logic [3:0] S_ADDI_EX = 4'd13;
`endif

    // Codes understood by the downstream ALU control
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_RTYPE = 3'b100;

    // ALU B operand selects
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Moore control word produced for each state
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

    // True for every opcode DECODE can dispatch
    function automatic logic op_known(input logic [5:0] op);
        logic k;
        k = (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
            (op == OP_ORI) || (op == OP_LW) || (op == OP_SW);
`ifdef MC_CTRL_ADDI_EN
        k = k || (op == OP_ADDI);
`endif
        return k;
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control word decoder for the main control.
// Optional macro MC_CTRL_ADDI_EN adds the ADDI_EX row.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
#(
    parameter int ST_W = 4
) (
    input  logic [ST_W-1:0] state_i,
    output ctrl_t           ctrl_o
);

    // Every field defaults to zero; each state raises only what it needs
    always_comb begin
        ctrl_o           = '0;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.alu_op    = ALU_ADD;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.ext_op    = 1'b1;
            end
            S_MEM_ADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.ext_op    = 1'b1;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_R_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_ORI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_OR;
            end
            S_IMM_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.ext_op    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Optional macro MC_CTRL_ADDI_EN enables addi via the ADDI_EX state.
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    output logic            pc_en,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            i_or_d,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            ext_op,
    output logic [1:0]      pc_source,
    output logic [2:0]      alu_op,
    output logic            illegal_op,
    output logic [ST_W-1:0] state
);

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_d;
    ctrl_t           ctrl;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    // Next-state sequencing; stray encodings recover through FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_RTYPE:     state_d = S_R_EX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ORI:       state_d = S_ORI_EX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADR: begin
                if (op == OP_LW)      state_d = S_MEM_RD;
                else if (op == OP_SW) state_d = S_MEM_WR;
                else                  state_d = S_FETCH;
            end
            S_MEM_RD:  state_d = S_MEM_WB;
            S_R_EX:    state_d = S_R_WB;
            S_ORI_EX:  state_d = S_IMM_WB;
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EX: state_d = S_IMM_WB;
`endif
            default:   state_d = S_FETCH;
        endcase
    end

    mc_ctrl_outdec #(
        .ST_W    (ST_W)
    ) u_outdec (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    // Output drive: Moore word plus the zero- and op-dependent signals
    always_comb begin
        pc_write      = ctrl.pc_write;
        pc_write_cond = ctrl.pc_write_cond;
        i_or_d        = ctrl.i_or_d;
        mem_read      = ctrl.mem_read;
        mem_write     = ctrl.mem_write;
        ir_write      = ctrl.ir_write;
        mem_to_reg    = ctrl.mem_to_reg;
        reg_dst       = ctrl.reg_dst;
        reg_write     = ctrl.reg_write;
        alu_src_a     = ctrl.alu_src_a;
        alu_src_b     = ctrl.alu_src_b;
        ext_op        = ctrl.ext_op;
        pc_source     = ctrl.pc_source;
        alu_op        = ctrl.alu_op;
        pc_en         = ctrl.pc_write | (ctrl.pc_write_cond & zero);
        illegal_op    = (state_q == S_DECODE) && !op_known(op);
        state         = state_q;
    end

endmodule
